// File: rtl/lab6_load_arbiter.sv
// lab6_load_arbiter
// Round-robin arbiter and write sequencer that shares one WIDTH-bit loadable
// register between NREQ requesters. Every write takes three cycles:
// IDLE (grant) -> LOAD (commit) -> HOLD (cooldown) -> IDLE.
//
// Ports
//   Clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   req     : request lines, bit i = requester i
//   data    : flattened request data, requester i at data[i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant
//   load    : registered load strobe to the register datapath
//   D       : registered data presented to the register datapath
//   Q       : committed register value
//   owner   : index of the requester that last wrote Q
//   valid   : high once Q has been written since reset
//   wr_cnt  : saturating count of completed writes
module lab6_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int CNTW  = 8
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     data,
  output logic [NREQ-1:0]           gnt,
  output logic                      load,
  output logic [WIDTH-1:0]          D,
  output logic [WIDTH-1:0]          Q,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      valid,
  output logic [CNTW-1:0]           wr_cnt
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [NREQ-1:0]   gnt_q,    gnt_d;
  logic              load_q,   load_d;
  logic [WIDTH-1:0]  dout_q,   dout_d;
  logic [WIDTH-1:0]  reg_q,    reg_d;
  logic [IDXW-1:0]   owner_q,  owner_d;
  logic              valid_q,  valid_d;
  logic [CNTW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [IDXW-1:0]   last_q,   last_d;

  // Round-robin winner: search from last+1 upward with wrap. The candidate
  // carries one extra bit so the wrap works for non-power-of-two NREQ.
  logic [IDXW:0]     cand;
  logic [IDXW-1:0]   win;
  logic              found;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) begin
        cand = cand - (IDXW+1)'(NREQ);
      end
      if (!found && req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    load_d   = load_q;
    dout_d   = dout_q;
    reg_d    = reg_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    wr_cnt_d = wr_cnt_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        // Data is captured here only; later changes cannot affect this write.
        if (found) begin
          state_d = LOAD;
          gnt_d   = NREQ'(1) << win;
          load_d  = 1'b1;
          dout_d  = data[int'(win)*WIDTH +: WIDTH];
          last_d  = win;
        end
      end
      LOAD: begin
        reg_d   = dout_q;
        owner_d = last_q;
        valid_d = 1'b1;
        if (wr_cnt_q != '1) begin
          wr_cnt_d = wr_cnt_q + CNTW'(1);
        end
        gnt_d   = '0;
        load_d  = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        // Cooldown: requests are ignored for one cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        load_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      load_q   <= 1'b0;
      dout_q   <= '0;
      reg_q    <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      wr_cnt_q <= '0;
      last_q   <= IDXW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      load_q   <= load_d;
      dout_q   <= dout_d;
      reg_q    <= reg_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      wr_cnt_q <= wr_cnt_d;
      last_q   <= last_d;
    end
  end

  assign gnt    = gnt_q;
  assign load   = load_q;
  assign D      = dout_q;
  assign Q      = reg_q;
  assign owner  = owner_q;
  assign valid  = valid_q;
  assign wr_cnt = wr_cnt_q;

endmodule
